// File: rtl/int_to_flopoco_6_6_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : flopoco_6_6_pkg
//  Description : Shared constants and word layout for FloPoCo (wE=6, wF=6)
//                operator cores.
//  Revision    : 1.0  initial release
// ============================================================================
package flopoco_6_6_pkg;

    localparam int WE   = 6;
    localparam int WF   = 6;
    localparam int BIAS = 31;
    localparam int FP_W = 2 + 1 + WE + WF;

    typedef enum logic [1:0] {
        EXC_ZERO   = 2'b00,
        EXC_NORMAL = 2'b01,
        EXC_INF    = 2'b10,
        EXC_NAN    = 2'b11
    } exc_e;

    typedef struct packed {
        exc_e            exc;
        logic            sign;
        logic [WE-1:0]   exp;
        logic [WF-1:0]   frac;
    } fp66_t;

endpackage : flopoco_6_6_pkg
`default_nettype wire

// File: rtl/int_to_flopoco_6_6_lzc16.sv
`default_nettype none
// ============================================================================
//  Module      : lzc16
//  Description : Combinational leading-one position encoder for a 16-bit
//                vector. Returns 0 for an all-zero input.
//  Revision    : 1.0  initial release
// ============================================================================
module lzc16 (
    input  logic [15:0] vec_i,
    output logic [3:0]  pos_o
);

    // Scan upward so the highest set bit is the last one to write pos_o
    always_comb begin
        pos_o = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (vec_i[i]) begin
                pos_o = i[3:0];
            end
        end
    end

endmodule : lzc16
`default_nettype wire

// File: rtl/int_to_flopoco_6_6.sv
`default_nettype none
// ============================================================================
//  Module      : int_to_flopoco_6_6
//  Description : Three-stage pipelined 16-bit signed integer to FloPoCo (6,6)
//                converter, round-to-nearest-even, valid/ready handshake
//                with full backpressure and bubble collapsing.
//  Revision    : 1.0  initial release
// ============================================================================
module int_to_flopoco_6_6
    import flopoco_6_6_pkg::*;
#(
    parameter int ID = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [14:0]   out_data
);

    // Stage valids
    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

    // S1: sign / magnitude / zero flag
    logic        sign1_q, sign1_d, zero1_q, zero1_d;
    logic [15:0] mag1_q, mag1_d;

    // S2: leading-one index and normalized mantissa; the leading one itself
    // (bit 15 of the normalized value) is implicit and not stored.
    logic        sign2_q, sign2_d, zero2_q, zero2_d;
    logic [3:0]  p2_q, p2_d;
    logic [14:0] norm2_q, norm2_d;

    // S3: packed result
    fp66_t       out_q, out_d;

    // Handshake wires
    logic w_ld1, w_ld2, w_ld3, w_adv3;

    // Datapath wires
    logic [3:0]  w_pos;
    logic [5:0]  w_frac;
    logic        w_guard, w_sticky, w_rnd;
    logic [6:0]  w_frac_sum;
    logic [5:0]  w_exp;

    lzc16 u_lzc16 (
        .vec_i (mag1_q),
        .pos_o (w_pos)
    );

    // A stage loads when the next one is empty or draining this cycle
    always_comb begin
        w_adv3   = v3_q & out_ready;
        w_ld3    = v2_q & (~v3_q | out_ready);
        w_ld2    = v1_q & (~v2_q | w_ld3);
        in_ready = ~v1_q | w_ld2;
        w_ld1    = in_valid & in_ready;
        v1_d     = w_ld1 | (v1_q & ~w_ld2);
        v2_d     = w_ld2 | (v2_q & ~w_ld3);
        v3_d     = w_ld3 | (v3_q & ~w_adv3);
    end

    // Next-state datapath for all three stages, holding when not loading
    always_comb begin
        sign1_d = sign1_q;
        zero1_d = zero1_q;
        mag1_d  = mag1_q;
        sign2_d = sign2_q;
        zero2_d = zero2_q;
        p2_d    = p2_q;
        norm2_d = norm2_q;
        out_d   = out_q;

        // Round-to-nearest-even on the top 6 fraction bits
        w_frac     = norm2_q[14:9];
        w_guard    = norm2_q[8];
        w_sticky   = |norm2_q[7:0];
        w_rnd      = w_guard & (w_sticky | w_frac[0]);
        w_frac_sum = {1'b0, w_frac} + {6'd0, w_rnd};
        // A fraction carry leaves frac at zero and bumps the exponent
        w_exp      = {2'b00, p2_q} + 6'(BIAS) + {5'd0, w_frac_sum[6]};

        if (w_ld1) begin
            sign1_d = in_data[15];
            zero1_d = (in_data == 16'd0);
            mag1_d  = in_data[15] ? (16'd0 - in_data) : in_data;
        end
        if (w_ld2) begin
            sign2_d = sign1_q;
            zero2_d = zero1_q;
            p2_d    = w_pos;
            norm2_d = mag1_q[14:0] << (4'd15 - w_pos);
        end
        if (w_ld3) begin
            if (zero2_q) begin
                out_d = '0;
            end else begin
                out_d.exc  = EXC_NORMAL;
                out_d.sign = sign2_q;
                out_d.exp  = w_exp;
                out_d.frac = w_frac_sum[5:0];
            end
        end
    end

    // Stage registers; reset empties the pipe and clears the output word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            sign1_q <= 1'b0;
            zero1_q <= 1'b0;
            mag1_q  <= '0;
            sign2_q <= 1'b0;
            zero2_q <= 1'b0;
            p2_q    <= '0;
            norm2_q <= '0;
            out_q   <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            sign1_q <= sign1_d;
            zero1_q <= zero1_d;
            mag1_q  <= mag1_d;
            sign2_q <= sign2_d;
            zero2_q <= zero2_d;
            p2_q    <= p2_d;
            norm2_q <= norm2_d;
            out_q   <= out_d;
        end
    end

    assign out_valid = v3_q;
    assign out_data  = out_q;

endmodule : int_to_flopoco_6_6
`default_nettype wire

// File: tb/tb_int_to_flopoco_6_6.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_to_flopoco_6_6
//  Description : Self-checking bench for int_to_flopoco_6_6.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_int_to_flopoco_6_6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [14:0] out_data;

    int checks = 0;
    int failures = 0;
    logic [14:0] exp_q[$];

    int_to_flopoco_6_6 #(.ID(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Reference conversion from arithmetic on the integer value
    function automatic logic [14:0] ref_conv(input int x);
        int a, e, sh, q, rem, half;
        logic s;
        if (x == 0) return 15'h0000;
        s = (x < 0);
        a = s ? -x : x;
        e = 0;
        while ((a >> (e + 1)) != 0) e++;
        if (e <= 6) begin
            q = a << (6 - e);
        end else begin
            sh   = e - 6;
            q    = a >> sh;
            rem  = a - (q << sh);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
            if (q == 128) begin
                q = 64;
                e++;
            end
        end
        return {2'b01, s, 6'(e + 31), 6'(q - 64)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 16'd7;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 15'h0000) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b out_data=%h required 0/0000", out_valid, out_data);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        repeat (5) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_accept: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_exact();
        int vals[5]       = '{0, 1, -1, 100, -32768};
        logic [14:0] r[5] = '{15'h0000, 15'h27C0, 15'h37C0, 15'h2964, 15'h3B80};
        int n;
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b1;
            in_valid = 1'b1;
            in_data = 16'(vals[i]);
            tick();
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (n !== 3 || out_data !== r[i]) begin
                failures++;
                $display("FAIL exact_%0d: latency=%0d data=%h required latency=3 data=%h", vals[i], n, out_data, r[i]);
            end
            tick();
        end
    endtask

    task automatic test_rounding();
        int vals[4]       = '{129, 131, 255, 32767};
        logic [14:0] r[4] = '{15'h2980, 15'h2982, 15'h29C0, 15'h2B80};
        int n;
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b1;
            in_valid = 1'b1;
            in_data = 16'(vals[i]);
            tick();
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (n !== 3 || out_data !== r[i]) begin
                failures++;
                $display("FAIL round_%0d: latency=%0d data=%h required latency=3 data=%h", vals[i], n, out_data, r[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, cyc = 0, bad = 0;
        logic [14:0] e;
        exp_q.delete();
        out_ready = 1'b1;
        while (got < 1000 && cyc < 1100) begin
            in_valid = (sent < 1000);
            in_data = 16'($urandom);
            #1;
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    bad++;
                    if (bad < 5)
                        $display("FAIL stream_data: item %0d got %h required %h", got, out_data, e);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_conv(int'($signed(in_data))));
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stream_mismatches: got %0d bad items required 0", bad);
        end
        checks++;
        if (got != 1000 || cyc != 1003) begin
            failures++;
            $display("FAIL stream_throughput: results=%0d cycles=%0d required 1000/1003", got, cyc);
        end
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0, cyc = 0, bad = 0, badrdy = 0, badstb = 0;
        logic prev_stall = 1'b0;
        logic [14:0] prev_data = '0;
        logic saw_full = 1'b0;
        logic exp_rdy;
        logic [14:0] e;
        exp_q.delete();
        while ((sent < 600 || got < sent) && cyc < 5000) begin
            out_ready = ($urandom_range(0, 99) >= 30);
            in_valid = (sent < 600) && ($urandom_range(0, 9) != 0);
            in_data = 16'($urandom);
            #1;
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) badstb++;
            exp_rdy = (exp_q.size() < 3) || out_ready;
            if (in_ready !== exp_rdy) badrdy++;
            if (exp_q.size() == 3 && !out_ready) saw_full = 1'b1;
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    bad++;
                    if (bad < 5)
                        $display("FAIL bp_data: item %0d got %h required %h", got, out_data, e);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_conv(int'($signed(in_data))));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (bad != 0 || got != 600) begin
            failures++;
            $display("FAIL bp_order: results=%0d bad=%0d required 600/0", got, bad);
        end
        checks++;
        if (badstb != 0) begin
            failures++;
            $display("FAIL bp_stable: %0d unstable stalled cycles required 0", badstb);
        end
        checks++;
        if (badrdy != 0 || !saw_full) begin
            failures++;
            $display("FAIL bp_in_ready: %0d wrong in_ready cycles, full_seen=%b required 0/1", badrdy, saw_full);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 16'(i + 10);
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 15'h0000) begin
            failures++;
            $display("FAIL midreset_clear: out_valid=%b out_data=%h required 0/0000", out_valid, out_data);
        end
        in_valid = 1'b1;
        in_data = 16'd5;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (out_valid) n++;
            tick();
        end
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL midreset_stale: %0d stale outputs required 0", n);
        end
        in_valid = 1'b1;
        in_data = 16'd1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 3 || out_data !== 15'h27C0) begin
            failures++;
            $display("FAIL midreset_after: latency=%0d data=%h required 3/27c0", n, out_data);
        end
        tick();
    endtask

    task automatic test_handshake_corner();
        int n = 0, bad = 0;
        logic [14:0] e;
        exp_q.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        while (n < 10) begin
            in_data = 16'($urandom);
            #1;
            if (!in_ready) break;
            exp_q.push_back(ref_conv(int'($signed(in_data))));
            tick();
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (exp_q.size() != 3 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL corner_fill: accepted=%0d in_ready=%b required 3/0", exp_q.size(), in_ready);
        end
        tick();
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_data = 16'd1000;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL corner_simul: in_ready=%b out_valid=%b required 1/1", in_ready, out_valid);
        end
        if (out_valid) begin
            e = exp_q.pop_front();
            if (out_data !== e) bad++;
        end
        if (in_ready) exp_q.push_back(ref_conv(1000));
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL corner_occupancy: in_ready=%b out_valid=%b required 0/1", in_ready, out_valid);
        end
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            #1;
            if (out_valid) begin
                e = exp_q.pop_front();
                if (out_data !== e) bad++;
            end
            tick();
            n++;
        end
        checks++;
        if (bad != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL corner_drain: bad=%0d left=%0d required 0/0", bad, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_rounding();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_handshake_corner();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_int_to_flopoco_6_6
`default_nettype wire
